// File: rtl/mg995_pkg.sv
// mg995_pkg: shared MG995 servo parameter set, angle-select and state encodings
//
// Contents:
//   DATA_W, PERIOD_CYC        frame counter width and clocks per 20 ms frame
//   DUTY_0_P/90_P/180_P       compare values for 0/90/180 deg (pulse = value+1 cycles)
//   SLEW_STEP                 maximum duty change per frame (SERVO_SLEW_EN builds only)
//   angle_e                   Angle_sel_i encodings ANG_0/ANG_90/ANG_180/ANG_HOLD
//   IDLE/RUN                  generator state encodings
//   low_p/high_p              output line levels
//   cmp_fits()                elaboration helper: compare value lies inside the frame
package mg995_pkg;

   localparam int DATA_W     = 20;
   localparam int PERIOD_CYC = 1000000;
   localparam int DUTY_0_P   = 24999;
   localparam int DUTY_90_P  = 74999;
   localparam int DUTY_180_P = 124999;
   localparam int SLEW_STEP  = 1000;

   typedef enum logic [1:0] {
      ANG_0    = 2'b00,
      ANG_90   = 2'b01,
      ANG_180  = 2'b10,
      ANG_HOLD = 2'b11
   } angle_e;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic low_p  = 1'b0;
   localparam logic high_p = 1'b1;

   function automatic bit cmp_fits(input int cmp, input int period);
      return (cmp >= 0) && (cmp < period);
   endfunction

endpackage

// File: rtl/mg995_pwm_gen_sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous switch inputs
//
// Parameters:
//   W        bus width
//   RST_VAL  value both flop stages take in reset
// Ports:
//   Clk_i    system clock
//   Reset_i  synchronous reset, active-low
//   Data_i   asynchronous input bus
//   Data_o   synchronized bus, two cycles of latency
module sync_2ff #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         Clk_i,
   input  logic         Reset_i,
   input  logic [W-1:0] Data_i,
   output logic [W-1:0] Data_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge Clk_i) begin
      if (!Reset_i) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= Data_i;
         sync_q <= meta_q;
      end
   end

   assign Data_o = sync_q;

endmodule

// File: rtl/mg995_pwm_gen.sv
// mg995_pwm_gen: 20 ms MG995 servo PWM frame generator with frame-aligned duty updates
//
// Optional feature: define SERVO_SLEW_EN to limit the duty change to SLEW_STEP per frame.
//
// Ports:
//   Clk_i          system clock (50 MHz)
//   Reset_i        synchronous reset, active-low
//   Enable_i       1 = generate frames, 0 = idle with the line low
//   Angle_sel_i    async switches: 00 = 0 deg, 01 = 90 deg, 10 = 180 deg, 11 = hold target
//   Pwm_o          registered servo control pulse, high for Duty_o+1 cycles per frame
//   Duty_o         active compare value, feeds the UART reporter's Data_i
//   Frame_start_o  one-cycle pulse in the cycle the frame counter is 0
module mg995_pwm_gen
   import mg995_pkg::*;
#(
   parameter int DATA_W     = mg995_pkg::DATA_W,
   parameter int PERIOD_CYC = mg995_pkg::PERIOD_CYC,
   parameter int DUTY_0_P   = mg995_pkg::DUTY_0_P,
   parameter int DUTY_90_P  = mg995_pkg::DUTY_90_P,
   parameter int DUTY_180_P = mg995_pkg::DUTY_180_P,
   parameter int SLEW_STEP  = mg995_pkg::SLEW_STEP
) (
   input  logic              Clk_i,
   input  logic              Reset_i,
   input  logic              Enable_i,
   input  logic [1:0]        Angle_sel_i,
   output logic              Pwm_o,
   output logic [DATA_W-1:0] Duty_o,
   output logic              Frame_start_o
);

   localparam logic [DATA_W-1:0] LAST_C = DATA_W'(PERIOD_CYC - 1);
   localparam logic [DATA_W-1:0] D0_C   = DATA_W'(DUTY_0_P);
   localparam logic [DATA_W-1:0] D90_C  = DATA_W'(DUTY_90_P);
   localparam logic [DATA_W-1:0] D180_C = DATA_W'(DUTY_180_P);

   // A compare value at or beyond the frame length would hold the line high forever.
   generate
      if (!cmp_fits(DUTY_0_P, PERIOD_CYC) || !cmp_fits(DUTY_90_P, PERIOD_CYC) ||
          !cmp_fits(DUTY_180_P, PERIOD_CYC)) begin : g_bad_duty
         $error("mg995_pwm_gen: compare values must be below PERIOD_CYC");
      end
      if ((PERIOD_CYC < 2) || (longint'(PERIOD_CYC) > (longint'(1) << DATA_W))) begin : g_bad_period
         $error("mg995_pwm_gen: PERIOD_CYC must fit the DATA_W-bit counter");
      end
      if (SLEW_STEP < 1) begin : g_bad_step
         $error("mg995_pwm_gen: SLEW_STEP must be at least 1");
      end
   endgenerate

   logic [1:0]        sel_s;
   logic [0:0]        state_q;
   logic [DATA_W-1:0] cnt_q;
   logic [DATA_W-1:0] target_q;
   logic [DATA_W-1:0] target_nxt;
   logic [DATA_W-1:0] duty_q;
   logic [DATA_W-1:0] duty_nxt;
   logic              pwm_q;
   logic              fs_q;
   logic              at_end;

   sync_2ff #(
      .W       (2),
      .RST_VAL (ANG_90)
   ) u_sel_sync (
      .Clk_i   (Clk_i),
      .Reset_i (Reset_i),
      .Data_i  (Angle_sel_i),
      .Data_o  (sel_s)
   );

   assign target_nxt = (sel_s == ANG_0)   ? D0_C   :
                       (sel_s == ANG_90)  ? D90_C  :
                       (sel_s == ANG_180) ? D180_C : target_q;

   assign at_end = (cnt_q == LAST_C);

`ifdef SERVO_SLEW_EN
   localparam logic [DATA_W-1:0] STEP_C = DATA_W'(SLEW_STEP);
   logic              up;
   logic [DATA_W-1:0] dist;
   // Within one step of the target the value lands exactly on it, so it never overshoots.
   always_comb begin
      up       = target_q > duty_q;
      dist     = up ? target_q - duty_q : duty_q - target_q;
      duty_nxt = (dist > STEP_C) ? (up ? duty_q + STEP_C : duty_q - STEP_C) : target_q;
   end
`else
   assign duty_nxt = target_q;
`endif

   // Duty only ever moves at the last count of a running frame, so every pulse
   // is governed by one compare value from start to finish.
   always_ff @(posedge Clk_i) begin
      if (!Reset_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         target_q <= D90_C;
         duty_q   <= D90_C;
         pwm_q    <= low_p;
         fs_q     <= 1'b0;
      end else begin
         target_q <= target_nxt;
         pwm_q    <= ((state_q == RUN) && (cnt_q <= duty_q)) ? high_p : low_p;
         if (state_q == IDLE) begin
            cnt_q   <= '0;
            state_q <= Enable_i ? RUN : IDLE;
            fs_q    <= Enable_i;
         end else if (!Enable_i) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            fs_q    <= 1'b0;
         end else begin
            cnt_q <= at_end ? '0 : cnt_q + DATA_W'(1);
            fs_q  <= at_end;
            if (at_end) duty_q <= duty_nxt;
         end
      end
   end

   assign Pwm_o         = pwm_q;
   assign Duty_o        = duty_q;
   assign Frame_start_o = fs_q;

endmodule

// File: tb/tb_mg995_pwm_gen.sv
// tb_mg995_pwm_gen: directed self-checking bench for mg995_pwm_gen on a scaled 200-cycle frame
module tb_mg995_pwm_gen;

   localparam int P    = 200;
   localparam int D0   = 24;
   localparam int D90  = 74;
   localparam int D180 = 124;
   localparam int STEP = 30;

   logic        Clk_i       = 1'b0;
   logic        Reset_i     = 1'b0;
   logic        Enable_i    = 1'b0;
   logic [1:0]  Angle_sel_i = 2'b01;
   logic        Pwm_o;
   logic [19:0] Duty_o;
   logic        Frame_start_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 Clk_i = ~Clk_i;

   mg995_pwm_gen #(
      .DATA_W     (20),
      .PERIOD_CYC (P),
      .DUTY_0_P   (D0),
      .DUTY_90_P  (D90),
      .DUTY_180_P (D180),
      .SLEW_STEP  (STEP)
   ) dut (
      .Clk_i         (Clk_i),
      .Reset_i       (Reset_i),
      .Enable_i      (Enable_i),
      .Angle_sel_i   (Angle_sel_i),
      .Pwm_o         (Pwm_o),
      .Duty_o        (Duty_o),
      .Frame_start_o (Frame_start_o)
   );

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk_i);
      #1;
   endtask

   // Starts on the sample where the counter is 0 and ends on the next frame's first sample.
   task automatic run_frame(input string tag, input int exp_hi, input int exp_duty,
                            input int chg_at, input logic [1:0] chg_sel);
      int hi = 0;
      int fs_bad = 0;
      int duty_bad = 0;
      for (int i = 0; i < P; i++) begin
         hi += int'(Pwm_o);
         if (Frame_start_o != (i == 0)) fs_bad++;
         if (int'(Duty_o) != exp_duty) duty_bad++;
         if (i == chg_at) Angle_sel_i = chg_sel;
         tick();
      end
      check({tag, "_high"}, hi, exp_hi);
      check({tag, "_fs"}, fs_bad, 0);
      check({tag, "_duty"}, duty_bad, 0);
   endtask

   task automatic idle_run(input string tag, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         if (Pwm_o || Frame_start_o) bad++;
         tick();
      end
      check(tag, bad, 0);
   endtask

   task automatic main_test();
      Angle_sel_i = 2'b00;
      repeat (5) tick();
      Enable_i = 1'b1;
      tick();
      run_frame("f1", D90 + 1, D90, -1, 2'b00);
      run_frame("f2", D0 + 1, D0, -1, 2'b00);
      run_frame("f3", D0 + 1, D0, 100, 2'b01);
      run_frame("f4", D90 + 1, D90, 30, 2'b10);
      run_frame("f5", D180 + 1, D180, 10, 2'b01);
      repeat (50) tick();
      Enable_i = 1'b0;
      tick();
      tick();
      check("dis_pwm", int'(Pwm_o), 0);
      check("dis_fs", int'(Frame_start_o), 0);
      check("dis_duty", int'(Duty_o), D90);
      Angle_sel_i = 2'b10;
      idle_run("dis_idle", 10);
      check("dis_duty_hold", int'(Duty_o), D90);
      Enable_i = 1'b1;
      tick();
      run_frame("reen", D90 + 1, D90, -1, 2'b00);
      Angle_sel_i = 2'b11;
      run_frame("hold1", D180 + 1, D180, -1, 2'b00);
      run_frame("hold2", D180 + 1, D180, -1, 2'b00);
      run_frame("hold3", D180 + 1, D180, -1, 2'b00);
      repeat (60) tick();
      check("rst_pre_pwm", int'(Pwm_o), 1);
      Reset_i = 1'b0;
      tick();
      check("rst_pwm", int'(Pwm_o), 0);
      check("rst_duty", int'(Duty_o), D90);
      check("rst_fs", int'(Frame_start_o), 0);
      Reset_i = 1'b1;
      tick();
      run_frame("post_rst", D90 + 1, D90, -1, 2'b00);
   endtask

   task automatic slew_test();
      Angle_sel_i = 2'b00;
      repeat (5) tick();
      Enable_i = 1'b1;
      tick();
      run_frame("s1", 75, 74, -1, 2'b00);
      run_frame("s2", 45, 44, -1, 2'b00);
      run_frame("s3", 25, 24, 10, 2'b10);
      run_frame("s4", 55, 54, -1, 2'b00);
      run_frame("s5", 85, 84, -1, 2'b00);
      run_frame("s6", 115, 114, -1, 2'b00);
      run_frame("s7", 125, 124, -1, 2'b00);
      run_frame("s8", 125, 124, -1, 2'b00);
   endtask

   initial begin
      repeat (5) tick();
      check("reset_pwm", int'(Pwm_o), 0);
      check("reset_duty", int'(Duty_o), D90);
      check("reset_fs", int'(Frame_start_o), 0);
      Reset_i = 1'b1;
      idle_run("released_idle", 20);
      check("released_duty", int'(Duty_o), D90);
`ifdef SERVO_SLEW_EN
      slew_test();
`else
      main_test();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
